// File: rtl/div_unit.sv
// div_unit: multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
// Ports: clk, rst (sync, active-high), signed_div_i, opdata1_i (dividend),
//        opdata2_i (divisor), start_i, annul_i -> result_o {rem, quot}, ready_o.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        ST_FREE,
        ST_BYZERO,
        ST_ON,
        ST_END
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [64:0] dividend;
    logic [31:0] divisor;
    logic        sign1;
    logic        sign2;

    logic        neg1;
    logic        neg2;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [32:0] diff;
    logic [31:0] quot;
    logic [31:0] rem;

    // Magnitudes are only consumed in FREE, when the operands are latched.
    assign neg1 = signed_div_i & opdata1_i[31];
    assign neg2 = signed_div_i & opdata2_i[31];
    assign abs1 = neg1 ? (~opdata1_i + 32'd1) : opdata1_i;
    assign abs2 = neg2 ? (~opdata2_i + 32'd1) : opdata2_i;

    // Trial subtraction of the divisor from the partial remainder.
    assign diff = {1'b0, dividend[63:32]} - {1'b0, divisor};

    // Quotient sign follows the operand signs; remainder follows the dividend.
    assign quot = (sign1 ^ sign2) ? (~dividend[31:0] + 32'd1)
                                  : dividend[31:0];
    assign rem  = sign1 ? (~dividend[64:33] + 32'd1)
                        : dividend[64:33];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FREE;
            cnt      <= 6'd0;
            dividend <= 65'd0;
            divisor  <= 32'd0;
            sign1    <= 1'b0;
            sign2    <= 1'b0;
            ready_o  <= 1'b0;
            result_o <= 64'd0;
        end else begin
            unique case (state)
                ST_FREE: begin
                    if (start_i && !annul_i) begin
                        sign1    <= neg1;
                        sign2    <= neg2;
                        cnt      <= 6'd0;
                        dividend <= {32'd0, abs1, 1'b0};
                        divisor  <= abs2;
                        if (opdata2_i == 32'd0) begin
                            state <= ST_BYZERO;
                        end else begin
                            state <= ST_ON;
                        end
                    end
                end
                ST_BYZERO: begin
                    if (annul_i) begin
                        state    <= ST_FREE;
                        cnt      <= 6'd0;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end else begin
                        state    <= ST_END;
                        ready_o  <= 1'b1;
                        result_o <= 64'd0;
                    end
                end
                ST_ON: begin
                    if (annul_i) begin
                        state    <= ST_FREE;
                        cnt      <= 6'd0;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end else if (cnt != 6'd32) begin
                        if (diff[32]) begin
                            dividend <= {dividend[63:0], 1'b0};
                        end else begin
                            dividend <= {diff[31:0], dividend[31:0], 1'b1};
                        end
                        cnt <= cnt + 6'd1;
                    end else begin
                        state    <= ST_END;
                        cnt      <= 6'd0;
                        ready_o  <= 1'b1;
                        result_o <= {rem, quot};
                    end
                end
                ST_END: begin
                    // Annul is ignored here; EX releases the result by
                    // dropping start.
                    if (!start_i) begin
                        state    <= ST_FREE;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end
                end
                default: begin
                    state <= ST_FREE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit.
// Driver pushes expected results; a monitor checks each ready_o rise.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    typedef struct {
        string       name;
        logic [63:0] res;
        int          lat;
        int          t0;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic ready_q = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk64(input string nm, input logic [63:0] act,
                         input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Monitor: every rising ready_o must match the oldest pending entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ready_o === 1'b1 && ready_q !== 1'b1) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_ready: got result %h, expected no ready",
                             result_o);
                end else begin
                    e = q.pop_front();
                    chk64({e.name, "_result"}, result_o, e.res);
                    chk64({e.name, "_latency"}, 64'(cyc - e.t0), 64'(e.lat));
                end
            end
            ready_q = ready_o;
        end
    end

    // Issue one division and hold start_i until ready, then release it.
    task automatic run(input string nm, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] res, input int lat,
                       input bit chg);
        exp_t e;
        bit   seen;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        e.name = nm;
        e.res  = res;
        e.lat  = lat;
        e.t0   = cyc;
        q.push_back(e);
        seen = 1'b0;
        for (int i = 1; i <= 60 && !seen; i++) begin
            @(negedge clk);
            if (chg && i == 5) begin
                opdata1_i    = 32'hDEAD_BEEF;
                signed_div_i = ~sgn;
            end
            if (ready_o === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got ready_o=0, expected 1", nm);
            void'(q.pop_front());
        end
        repeat (2) @(negedge clk);
        chk64({nm, "_hold_ready"}, 64'(ready_o), 64'd1);
        chk64({nm, "_hold_result"}, result_o, res);
        start_i = 1'b0;
        @(negedge clk);
        chk64({nm, "_drop_ready"}, 64'(ready_o), 64'd0);
        chk64({nm, "_drop_result"}, result_o, 64'd0);
    endtask

    initial begin
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (3) @(negedge clk);
        chk64("reset_ready", 64'(ready_o), 64'd0);
        chk64("reset_result", result_o, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run("u100_7", 1'b0, 32'd100, 32'd7,
            64'h00000002_0000000E, 34, 1'b0);
        run("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2,
            64'hFFFFFFFF_FFFFFFFD, 34, 1'b0);
        run("s7_m2", 1'b1, 32'd7, 32'hFFFFFFFE,
            64'h00000001_FFFFFFFD, 34, 1'b0);
        run("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF,
            64'h00000000_80000000, 34, 1'b0);
        run("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1,
            64'h00000000_FFFFFFFF, 34, 1'b0);
        run("div0", 1'b1, 32'd1234, 32'd0,
            64'd0, 2, 1'b0);

        // Abort partway through ON; no result may appear.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (10) @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        chk64("annul_ready", 64'(ready_o), 64'd0);
        repeat (40) @(negedge clk);
        chk64("annul_quiet", 64'(ready_o), 64'd0);
        run("u50_5", 1'b0, 32'd50, 32'd5,
            64'h00000000_0000000A, 34, 1'b0);

        // Reset in the middle of an iteration.
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (20) @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        chk64("rst_mid_ready", 64'(ready_o), 64'd0);
        chk64("rst_mid_result", result_o, 64'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk64("rst_mid_quiet", 64'(ready_o), 64'd0);

        run("opchg", 1'b0, 32'd1000, 32'd7,
            64'h00000006_0000008E, 34, 1'b1);

        repeat (3) @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL pending: got %0d entries, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
